kernel_read_assist: RTL and testbench
=====================================

// Module: kernel_read_assist
// PURPOSE
//  Read-side companion of the kernel write path. Walks kernel RAM as (bank=quotient, offset=remainder) for
//  kernel_count consecutive kernels of DIVISOR words each, issues RAM reads, and re-tags the returned words.
//  Output is a valid/ready stream carrying quotient, remainder and the recombined linear index q*DIVISOR+r.
//  Sits between the kernel RAM banks and the conv PE weight loader.
// PARAMETERS
//  DIVIDEND_WIDTH  20   linear index width; quotient/remainder are DIVIDEND_WIDTH/2 bits
//  DIVISOR         288  words per kernel (offset wraps at DIVISOR-1)
//  DATA_WIDTH      16   kernel word width
//  RAM_LATENCY     2    cycles from rd_en to valid rd_data (>=1)
//  FIFO_DEPTH      4    output buffer entries; must be >= RAM_LATENCY+1
// PORTS
//  clk           in   1                 clock, rising edge
//  rst_n         in   1                 async active-low reset
//  start         in   1                 begin a pass (sampled only in IDLE)
//  kernel_first  in   DIVIDEND_WIDTH/2  first bank (quotient) to read
//  kernel_count  in   DIVIDEND_WIDTH/2  number of kernels to read
//  busy          out  1                 high from accepted start until done
//  done          out  1                 one-cycle pulse, pass complete
//  rd_en         out  1                 RAM read strobe
//  rd_bank       out  DIVIDEND_WIDTH/2  RAM bank select (quotient)
//  rd_offset     out  DIVIDEND_WIDTH/2  RAM word offset (remainder)
//  rd_data       in   DATA_WIDTH        RAM read data, valid RAM_LATENCY cycles after rd_en
//  o_data        out  DATA_WIDTH        output word
//  o_quotient    out  DIVIDEND_WIDTH/2  tag: bank of o_data
//  o_remainder   out  DIVIDEND_WIDTH/2  tag: offset of o_data
//  o_linear      out  DIVIDEND_WIDTH    tag: o_quotient*DIVISOR+o_remainder (see CONFIGURATION)
//  o_valid       out  1                 output word valid
//  o_ready       in   1                 downstream accepts; transfer when o_valid&o_ready
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, in-flight tag pipeline cleared. Reset mid-pass aborts, no done.
//  FSM: IDLE -start&count!=0-> RUN; IDLE -start&count==0-> DONE; RUN -last read issued-> DRAIN;
//   DRAIN -FIFO empty & no reads in flight-> DONE; DONE -> IDLE (done=1 for that single cycle).
//  busy=1 in RUN/DRAIN/DONE. start while busy ignored. kernel_first/kernel_count latched on accepted start.
//  Issue: rd_en=1 in RUN when (in_flight + fifo_count) < FIFO_DEPTH; never overflows FIFO regardless of o_ready.
//  First read: bank=kernel_first, offset=0 in cycle after accepted start. Per issue offset++; at DIVISOR-1
//   offset->0, bank++. Last read: bank=kernel_first+kernel_count-1, offset=DIVISOR-1. Bank add wraps mod 2^(W/2).
//  Tags (bank,offset,linear) delayed RAM_LATENCY cycles alongside rd_en; pushed into FIFO with rd_data.
//  Output: FIFO head, first-word-fall-through; min latency rd_en -> o_valid = RAM_LATENCY+1 cycles.
//  Simultaneous push and pop on full FIFO allowed (count unchanged). o_data/tags held stable while o_valid&!o_ready.
//  Order of output words strictly equals issue order; exactly kernel_count*DIVISOR words per pass.
//  linear: latched kernel_first*DIVISOR (constant multiply) on start, +1 per issue, wraps mod 2^DIVIDEND_WIDTH.
// CONFIGURATION
//  KERNEL_READ_ASSIST_LINEAR_EN defined: linear accumulator and its tag pipeline/FIFO field built; o_linear valid.
//  Not defined: no linear logic; o_linear tied to 0. All other behaviour identical.
// TESTING
//  1 reset, idle: all outputs 0; start with kernel_count=0 -> done pulse 2 cycles later, no rd_en, no o_valid.
//  2 kernel_first=3, count=1, o_ready=1 -> 288 reads bank 3 offset 0..287; outputs in order, o_linear 864..1151;
//    done after last transfer.
//  3 kernel_first=0, count=2 -> offset 287 bank0 followed by offset 0 bank1; o_linear 287 then 288; 576 words.
//  4 o_ready=0 throughout RUN -> exactly FIFO_DEPTH reads issued then rd_en stalls; release -> no word lost/duplicated.
//  5 random o_ready (50%) over count=3 -> scoreboard matches RAM model, 864 words, single done pulse.
//  6 rst_n low mid-RUN with words in flight -> outputs 0 immediately; new start yields clean pass from offset 0.
//  Run 2 and 3 with and without KERNEL_READ_ASSIST_LINEAR_EN (o_linear=0 when undefined).

Source files
------------

// File: rtl/kernel_read_assist.sv
// kernel_read_assist: walks kernel RAM as (bank, offset) and streams the returned words, re-tagged, in issue order.
// The KERNEL_READ_ASSIST_LINEAR_EN macro builds the linear-index tag; when it is undefined, o_linear is tied to 0.
module kernel_read_assist #(
  parameter int DIVIDEND_WIDTH = 20,
  parameter int DIVISOR        = 288,
  parameter int DATA_WIDTH     = 16,
  parameter int RAM_LATENCY    = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DIVIDEND_WIDTH/2-1:0]   kernel_first,
  input  logic [DIVIDEND_WIDTH/2-1:0]   kernel_count,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [DIVIDEND_WIDTH/2-1:0]   rd_bank,
  output logic [DIVIDEND_WIDTH/2-1:0]   rd_offset,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [DIVIDEND_WIDTH/2-1:0]   o_quotient,
  output logic [DIVIDEND_WIDTH/2-1:0]   o_remainder,
  output logic [DIVIDEND_WIDTH-1:0]     o_linear,
  output logic                          o_valid,
  input  logic                          o_ready
);
  localparam int W  = DIVIDEND_WIDTH;
  localparam int H  = DIVIDEND_WIDTH / 2;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RAM_LATENCY + 1) + 1;
  localparam logic [H-1:0]  OFF_LAST = H'(DIVISOR - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [H-1:0]    bank_q, bank_d, offset_q, offset_d, last_bank_q, last_bank_d;
  logic            pipe_vld_q  [RAM_LATENCY];
  logic            pipe_vld_d  [RAM_LATENCY];
  logic [H-1:0]    pipe_bank_q [RAM_LATENCY];
  logic [H-1:0]    pipe_bank_d [RAM_LATENCY];
  logic [H-1:0]    pipe_off_q  [RAM_LATENCY];
  logic [H-1:0]    pipe_off_d  [RAM_LATENCY];
  logic [DATA_WIDTH-1:0] mem_dat_q [FIFO_DEPTH];
  logic [H-1:0]    mem_bank_q [FIFO_DEPTH];
  logic [H-1:0]    mem_off_q  [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d, in_flight;
  logic            issue, last_issue, push, pop;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) in_flight = in_flight + CW'(pipe_vld_q[i]);
    // Reserve a FIFO slot for every read still in the RAM so o_ready never matters for overflow.
    issue      = (state_q == RUN) && ((in_flight + cnt_q) < DEPTH_C);
    last_issue = issue && (bank_q == last_bank_q) && (offset_q == OFF_LAST);
    push       = pipe_vld_q[RAM_LATENCY-1];
    pop        = (cnt_q != '0) && o_ready;

    state_d     = state_q;
    bank_d      = bank_q;
    offset_d    = offset_q;
    last_bank_d = last_bank_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bank_d      = kernel_first;
          offset_d    = '0;
          last_bank_d = kernel_first + kernel_count - H'(1);
          state_d     = (kernel_count != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (issue) begin
          if (offset_q == OFF_LAST) begin
            offset_d = '0;
            bank_d   = bank_q + H'(1);
          end else begin
            offset_d = offset_q + H'(1);
          end
        end
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if ((cnt_q == '0) && (in_flight == '0)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    pipe_vld_d[0]  = issue;
    pipe_bank_d[0] = bank_q;
    pipe_off_d[0]  = offset_q;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_bank_d[i] = pipe_bank_q[i-1];
      pipe_off_d[i]  = pipe_off_q[i-1];
    end

    wr_ptr_d = push ? ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bank_q      <= '0;
      offset_q    <= '0;
      last_bank_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_bank_q[i] <= '0;
        pipe_off_q[i]  <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_dat_q[i]  <= '0;
        mem_bank_q[i] <= '0;
        mem_off_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      offset_q    <= offset_d;
      last_bank_q <= last_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_d[i];
        pipe_bank_q[i] <= pipe_bank_d[i];
        pipe_off_q[i]  <= pipe_off_d[i];
      end
      if (push) begin
        mem_dat_q[wr_ptr_q]  <= rd_data;
        mem_bank_q[wr_ptr_q] <= pipe_bank_q[RAM_LATENCY-1];
        mem_off_q[wr_ptr_q]  <= pipe_off_q[RAM_LATENCY-1];
      end
    end
  end

`ifdef KERNEL_READ_ASSIST_LINEAR_EN
  logic [W-1:0] lin_q, lin_d;
  logic [W-1:0] pipe_lin_q [RAM_LATENCY];
  logic [W-1:0] pipe_lin_d [RAM_LATENCY];
  logic [W-1:0] mem_lin_q  [FIFO_DEPTH];

  always_comb begin
    lin_d = lin_q;
    if ((state_q == IDLE) && start) lin_d = W'(kernel_first) * W'(DIVISOR);
    else if (issue)                 lin_d = lin_q + W'(1);
    pipe_lin_d[0] = lin_q;
    for (int i = 1; i < RAM_LATENCY; i++) pipe_lin_d[i] = pipe_lin_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lin_q <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) pipe_lin_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)  mem_lin_q[i]  <= '0;
    end else begin
      lin_q <= lin_d;
      for (int i = 0; i < RAM_LATENCY; i++) pipe_lin_q[i] <= pipe_lin_d[i];
      if (push) mem_lin_q[wr_ptr_q] <= pipe_lin_q[RAM_LATENCY-1];
    end
  end

  assign o_linear = o_valid ? mem_lin_q[rd_ptr_q] : '0;
`else
  assign o_linear = '0;
`endif

  // Head of FIFO is presented directly; outputs read 0 whenever nothing is valid.
  assign o_valid     = (cnt_q != '0);
  assign o_data      = o_valid ? mem_dat_q[rd_ptr_q]  : '0;
  assign o_quotient  = o_valid ? mem_bank_q[rd_ptr_q] : '0;
  assign o_remainder = o_valid ? mem_off_q[rd_ptr_q]  : '0;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign rd_en       = issue;
  assign rd_bank     = bank_q;
  assign rd_offset   = offset_q;
endmodule

// File: tb/tb_kernel_read_assist.sv
// Bench for kernel_read_assist: RAM model, expected-word queue filled per pass, decoupled output monitor.
module tb_kernel_read_assist;
  localparam int DIV = 288;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  kernel_first = '0;
  logic [9:0]  kernel_count = '0;
  logic        busy, done, rd_en, o_valid;
  logic        o_ready = 1'b1;
  logic [9:0]  rd_bank, rd_offset, o_quotient, o_remainder;
  logic [15:0] rd_data, o_data;
  logic [19:0] o_linear;

  kernel_read_assist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_first(kernel_first),
    .kernel_count(kernel_count), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_bank(rd_bank), .rd_offset(rd_offset), .rd_data(rd_data), .o_data(o_data),
    .o_quotient(o_quotient), .o_remainder(o_remainder), .o_linear(o_linear),
    .o_valid(o_valid), .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ram_word(input logic [9:0] b, input logic [9:0] o);
    return {b[5:0], o} ^ 16'h5A5A;
  endfunction

  // RAM with two cycles of read latency.
  logic [9:0] ram_b [2];
  logic [9:0] ram_o [2];
  always @(posedge clk) begin
    ram_b[0] <= rd_bank;  ram_o[0] <= rd_offset;
    ram_b[1] <= ram_b[0]; ram_o[1] <= ram_o[0];
  end
  assign rd_data = ram_word(ram_b[1], ram_o[1]);

  typedef struct packed {
    logic [15:0] d;
    logic [9:0]  q;
    logic [9:0]  r;
    logic [19:0] l;
  } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, rd_cnt = 0, ovld_cnt = 0, xfer_cnt = 0, last_xfer = 0;
  int rdy_mode = 0;
  logic  hold_prev = 1'b0;
  exp_t  hold_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = 1'($urandom_range(0, 1));
      default: o_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every transfer, checks hold-stability during stalls.
  always @(negedge clk) begin
    exp_t cur, e;
    cyc++;
    cur = '{d: o_data, q: o_quotient, r: o_remainder, l: o_linear};
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (rd_en) rd_cnt++;
      if (o_valid) ovld_cnt++;
      if (hold_prev) begin
        chk("hold_valid", 64'(o_valid), 64'd1);
        chk("hold_word", 64'(cur), 64'(hold_word));
      end
      hold_prev = o_valid && !o_ready;
      hold_word = cur;
      if (o_valid && o_ready) begin
        xfer_cnt++;
        last_xfer = cyc;
        if (exp_q.size() == 0) chk("extra_word", 64'(cur), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("word", 64'(cur), 64'(e));
        end
      end
    end
  end

  task automatic push_expected(input logic [9:0] first, input logic [9:0] cnt);
    logic [19:0] lin;
    lin = 20'(first) * 20'(DIV);
    for (int b = 0; b < int'(cnt); b++)
      for (int o = 0; o < DIV; o++) begin
        exp_t e;
        e.q = first + 10'(b);
        e.r = 10'(o);
        e.d = ram_word(e.q, e.r);
`ifdef KERNEL_READ_ASSIST_LINEAR_EN
        e.l = lin;
`else
        e.l = '0;
`endif
        lin = lin + 20'd1;
        exp_q.push_back(e);
      end
  endtask

  task automatic issue_start(input logic [9:0] first, input logic [9:0] cnt);
    @(posedge clk); #1;
    kernel_first = first; kernel_count = cnt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin @(posedge clk); n++; end
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
    repeat (4) @(posedge clk);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic run_pass(input string tag, input logic [9:0] first, input logic [9:0] cnt, input int mode);
    int d0, x0;
    d0 = done_cnt; x0 = xfer_cnt;
    rdy_mode = mode;
    push_expected(first, cnt);
    issue_start(first, cnt);
    wait_done(d0, 4000);
    chk({tag, "_words"}, 64'(xfer_cnt - x0), 64'(int'(cnt) * DIV));
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_done_after_xfer"}, 64'(done_cyc > last_xfer), 64'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'({rd_bank, rd_offset}), 64'd0);
    chk({tag, "_o_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_o_word"}, 64'({o_data, o_quotient, o_remainder, o_linear}), 64'd0);
  endtask

  initial begin
    int d0, r0, v0, x0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Zero-kernel pass: done only, no reads, no output.
    d0 = done_cnt; r0 = rd_cnt; v0 = ovld_cnt;
    issue_start(10'd4, 10'd0);
    wait_done(d0, 20);
    chk("zero_rd_en", 64'(rd_cnt - r0), 64'd0);
    chk("zero_o_valid", 64'(ovld_cnt - v0), 64'd0);

    run_pass("k3", 10'd3, 10'd1, 0);
    run_pass("k0x2", 10'd0, 10'd2, 0);

    // Downstream stalled: reads stop once the FIFO budget is spent.
    d0 = done_cnt; r0 = rd_cnt; x0 = xfer_cnt;
    rdy_mode = 2;
    push_expected(10'd5, 10'd1);
    issue_start(10'd5, 10'd1);
    repeat (30) @(posedge clk);
    #2;
    chk("stall_reads", 64'(rd_cnt - r0), 64'd4);
    chk("stall_valid", 64'(o_valid), 64'd1);
    rdy_mode = 0;
    wait_done(d0, 4000);
    chk("stall_words", 64'(xfer_cnt - x0), 64'(DIV));
    chk("stall_sb_empty", 64'(exp_q.size()), 64'd0);

    run_pass("rand", 10'd7, 10'd3, 1);

    // Reset in the middle of a pass.
    d0 = done_cnt;
    rdy_mode = 0;
    push_expected(10'd2, 10'd2);
    issue_start(10'd2, 10'd2);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    run_pass("after_rst", 10'd9, 10'd1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
